rr_arb16: RTL and testbench
===========================

# rr_arb16

Round-robin arbiter that shares one 16-way resource between 16 requesters. It selects one winner, holds the grant while that requester keeps asserting its request, and enforces a maximum hold time. It drives both a 4-bit encoded index and the equivalent one-hot 16-bit grant. The block sits in front of the 4-to-16 select logic, so the decoded grant lines and the encoded select always agree.

## Interface
- HOLD_MAX, 8: maximum number of consecutive cycles one grant may stay high. Legal range is 1..255.
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- Enable  in  1  when 1, new grants may be issued; when 0, no new grant starts.
- Req  in  [0:15]  request lines; Req[i] belongs to requester i.
- Grant  out  [0:15]  one-hot grant; Grant[i] = Valid & (Index == i).
- Index  out  [3:0]  encoded number of the current winner.
- Valid  out  1  a grant is active.
- Timeout  out  1  one-cycle pulse when a grant is revoked because HOLD_MAX was reached.

## Operation
- State machine: IDLE and GRANT. Internal registers:
  - Ptr [3:0], the round-robin priority pointer.
  - Cnt [7:0], the hold counter.
- All outputs are registered.
- Reset (Resetn=0, takes effect immediately, not on the clock):
  - State=IDLE, Ptr=0, Cnt=0.
  - Index=0, Valid=0, Grant=0, Timeout=0.
- IDLE, with Enable=1 and Req nonzero, at a clock edge:
  - Winner = the first i with Req[i]=1, searching Ptr, Ptr+1, … 15, 0, … Ptr-1 (mod 16).
  - Index←winner, Valid←1, Cnt←1, State←GRANT.
- IDLE, with Enable=0 or Req all zero: stay in IDLE, Valid=0, Ptr unchanged.
- GRANT, at each clock edge, checked in priority order:
  1. Req[Index]=0 (release): State←IDLE, Valid←0, Ptr←Index+1 mod 16, Timeout←0.
  2. Else Cnt==HOLD_MAX (timeout): State←IDLE, Valid←0, Ptr←Index+1 mod 16, Timeout←1.
  3. Else: Cnt←Cnt+1, all other registers hold.
- Enable has no effect in GRANT: a grant in progress always finishes by release or timeout.
- Timeout is 1 only in the cycle right after a timeout edge; it is 0 on every other edge.
- Index keeps its last value while Valid=0. Grant must be all zeros whenever Valid=0.
- Ptr changes only when a grant ends, never at the moment a grant is issued.
- Wrap-around: a winner of 15 sets Ptr to 0.
- Requests from requesters other than Index are ignored during GRANT. They are considered at the next arbitration.

## Timing
- Request to grant latency: 1 edge. A request sampled at edge t in IDLE makes Grant high from edge t onward.
- Release: Req[Index] sampled low at edge t makes Grant low after edge t.
- Timeout: Grant is high for exactly HOLD_MAX cycles. With HOLD_MAX=1, Grant is high for exactly 1 cycle.
- Minimum 1 dead cycle (Valid=0) between two grants, even for back-to-back requests. Maximum grant rate is one grant every 2 cycles.
- Release and timeout in the same edge (request drops on the edge where Cnt==HOLD_MAX): release wins and Timeout stays 0.
- Worst-case wait for a continuously requesting line: 15 × (HOLD_MAX + 1) cycles.
- Reset asserted in the middle of a grant: Grant, Valid and Timeout drop to 0 immediately. After reset is released, the first arbitration starts with Ptr=0.

## Test plan
- Reset values: hold Resetn=0 with Req=16'hFFFF → Grant=0, Valid=0, Index=0, Timeout=0. Release reset with Req[0:15] having only bits 3 and 9 set → Index=3 after the first edge, Grant[3]=1.
- Rotation: HOLD_MAX=8, all Req high, each requester drops its own Req 2 cycles after being granted → Index sequence 0,1,2,…,15,0. Exactly one dead cycle between grants. Timeout never asserted.
- Timeout: HOLD_MAX=4, Req[5] held high with no other requests → Grant[5] high for 4 cycles, then 1 cycle with Timeout=1 and Valid=0, then Grant[5] is granted again.
- Wrap and priority skip: Ptr=14 (after a grant to 13 ends), only Req[2] and Req[12] high → Index=2, not 12. Then Ptr=3 → Index=12.
- Enable gating and simultaneous events: Enable=0 with Req=16'hFFFF → Valid stays 0. Drop Enable during an active grant → grant continues until release. With HOLD_MAX=3, drop the request on the 3rd grant cycle → Timeout=0.
- Asynchronous reset during a grant: assert Resetn=0 between clock edges while Grant[7]=1 → Grant goes to 0 before the next edge. After reset is released, the next winner is the lowest set request starting from requester 0.

Source files
------------

// File: rtl/rr_arb16.sv
// rr_arb16: 16-way round-robin arbiter with grant hold and hold-time limit.
// Ports: Clock, Resetn (async low), Enable, Req[0:15] in; Grant[0:15], Index, Valid, Timeout out.
module rr_arb16 #(
   parameter int HOLD_MAX = 8
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Enable,
   input  logic [0:15] Req,
   output logic [0:15] Grant,
   output logic [3:0]  Index,
   output logic        Valid,
   output logic        Timeout
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  index_q, index_d;
   logic        valid_q, valid_d;
   logic        timeout_q, timeout_d;
   logic [0:15] grant_q, grant_d;

   logic        found;
   logic [3:0]  win;
   logic [3:0]  idx;

   // Search Ptr, Ptr+1, ... wrapping mod 16; first hit wins.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      idx   = ptr_q;
      for (int k = 0; k < 16; k++) begin
         idx = ptr_q + 4'(k);
         if (!found && Req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      index_d   = index_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            valid_d = 1'b0;
            if (Enable && found) begin
               index_d = win;
               valid_d = 1'b1;
               cnt_d   = 8'd1;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            // Release takes priority over timeout on the same edge.
            if (!Req[index_q]) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               ptr_d   = index_q + 4'd1;
            end else if (cnt_q == 8'(HOLD_MAX)) begin
               state_d   = S_IDLE;
               valid_d   = 1'b0;
               ptr_d     = index_q + 4'd1;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // Decode from the next-state values so Grant is itself a flop
   // and always matches Valid/Index.
   always_comb begin
      grant_d = '0;
      if (valid_d) grant_d[index_d] = 1'b1;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= S_IDLE;
         ptr_q     <= 4'd0;
         cnt_q     <= 8'd0;
         index_q   <= 4'd0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         grant_q   <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         index_q   <= index_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         grant_q   <= grant_d;
      end
   end

   assign Grant   = grant_q;
   assign Index   = index_q;
   assign Valid   = valid_q;
   assign Timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb16.sv
// tb_rr_arb16: directed checks of rr_arb16 at HOLD_MAX 8, 4 and 3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rr_arb16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        en8, en4, en3;
   logic [0:15] req8, req4, req3;
   logic [0:15] gnt8, gnt4, gnt3;
   logic [3:0]  idx8, idx4, idx3;
   logic        vld8, vld4, vld3;
   logic        to8, to4, to3;

   int n_tests = 0;
   int n_fail  = 0;

   rr_arb16 #(.HOLD_MAX(8)) u8 (
      .Clock(clk), .Resetn(rst_n), .Enable(en8), .Req(req8),
      .Grant(gnt8), .Index(idx8), .Valid(vld8), .Timeout(to8)
   );
   rr_arb16 #(.HOLD_MAX(4)) u4 (
      .Clock(clk), .Resetn(rst_n), .Enable(en4), .Req(req4),
      .Grant(gnt4), .Index(idx4), .Valid(vld4), .Timeout(to4)
   );
   rr_arb16 #(.HOLD_MAX(3)) u3 (
      .Clock(clk), .Resetn(rst_n), .Enable(en3), .Req(req3),
      .Grant(gnt3), .Index(idx3), .Valid(vld3), .Timeout(to3)
   );

   function automatic logic [0:15] oh(input int i);
      logic [0:15] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic chk_g8(input string tag, input int i);
      chk({tag, " vld"}, 32'(vld8), 32'd1);
      chk({tag, " idx"}, 32'(idx8), 32'(i));
      chk({tag, " gnt"}, 32'(gnt8), 32'(oh(i)));
      chk({tag, " to"},  32'(to8),  32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      en8 = 1'b1; en4 = 1'b1; en3 = 1'b1;
      req8 = 16'hFFFF; req4 = '0; req3 = '0;

      // Reset values with all requests high
      repeat (2) @(negedge clk);
      chk("rst gnt", 32'(gnt8), 32'd0);
      chk("rst vld", 32'(vld8), 32'd0);
      chk("rst idx", 32'(idx8), 32'd0);
      chk("rst to",  32'(to8),  32'd0);
      req8 = oh(3) | oh(9);
      rst_n = 1'b1;
      @(negedge clk);
      chk_g8("first", 3);
      req8 = '0;
      @(negedge clk);
      chk("first rel", 32'(vld8), 32'd0);

      // Rotation 0..15,0 with one dead cycle each
      do_reset();
      req8 = 16'hFFFF;
      for (int g = 0; g < 17; g++) begin
         @(negedge clk);
         chk_g8("rot c1", g % 16);
         @(negedge clk);
         chk_g8("rot c2", g % 16);
         if (g == 16) req8 = '0;
         else req8[g % 16] = 1'b0;
         @(negedge clk);
         chk("rot dead", 32'(vld8), 32'd0);
         chk("rot dgnt", 32'(gnt8), 32'd0);
         chk("rot dto", 32'(to8), 32'd0);
         if (g != 16) req8[g % 16] = 1'b1;
      end

      // Enable gating (Ptr is now 1)
      en8 = 1'b0;
      req8 = 16'hFFFF;
      repeat (3) begin
         @(negedge clk);
         chk("en0 vld", 32'(vld8), 32'd0);
      end
      en8 = 1'b1;
      @(negedge clk);
      chk_g8("en1", 1);
      en8 = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk_g8("en drop", 1);
      end
      req8 = '0;
      @(negedge clk);
      chk("en rel vld", 32'(vld8), 32'd0);
      chk("en rel to", 32'(to8), 32'd0);

      // Timeout at HOLD_MAX=4 on requester 5
      req4 = oh(5);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("tmo vld", 32'(vld4), 32'd1);
         chk("tmo gnt", 32'(gnt4), 32'(oh(5)));
         chk("tmo to0", 32'(to4), 32'd0);
      end
      @(negedge clk);
      chk("tmo pulse", 32'(to4), 32'd1);
      chk("tmo pvld", 32'(vld4), 32'd0);
      chk("tmo pgnt", 32'(gnt4), 32'd0);
      @(negedge clk);
      chk("tmo regr vld", 32'(vld4), 32'd1);
      chk("tmo regr idx", 32'(idx4), 32'd5);
      chk("tmo regr to", 32'(to4), 32'd0);
      req4 = '0;
      @(negedge clk);
      chk("tmo rel", 32'(vld4), 32'd0);

      // Wrap and priority skip
      req4 = oh(13);
      @(negedge clk);
      chk("wrap 13", 32'(idx4), 32'd13);
      req4 = oh(2) | oh(12);
      @(negedge clk);
      chk("wrap dead", 32'(vld4), 32'd0);
      @(negedge clk);
      chk("wrap idx2", 32'(idx4), 32'd2);
      chk("wrap gnt2", 32'(gnt4), 32'(oh(2)));
      req4 = oh(12);
      @(negedge clk);
      chk("wrap dead2", 32'(vld4), 32'd0);
      @(negedge clk);
      chk("wrap idx12", 32'(idx4), 32'd12);
      chk("wrap vld12", 32'(vld4), 32'd1);
      req4 = '0;

      // Release on the HOLD_MAX edge at HOLD_MAX=3
      req3 = oh(4);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("sim vld", 32'(vld3), 32'd1);
         chk("sim idx", 32'(idx3), 32'd4);
      end
      req3 = '0;
      @(negedge clk);
      chk("sim to", 32'(to3), 32'd0);
      chk("sim vld0", 32'(vld3), 32'd0);
      @(negedge clk);
      chk("sim to2", 32'(to3), 32'd0);

      // Async reset in the middle of a grant to 7
      en8 = 1'b1;
      req8 = oh(7);
      @(negedge clk);
      chk_g8("ar g7", 7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar gnt", 32'(gnt8), 32'd0);
      chk("ar vld", 32'(vld8), 32'd0);
      chk("ar to",  32'(to8),  32'd0);
      req8 = oh(1) | oh(12);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_g8("ar next", 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
